falafel_req_fifo: RTL

//  Request queue directly downstream of the input parser: buffers parsed alloc_entry_t
//  {id,size} requests (one instance each for the alloc and free paths) and presents them
//  to the allocator core over a valid/ready interface.

---
 rtl/falafel_req_fifo.sv | 98 +++++++++
 1 files changed

// File: rtl/falafel_req_fifo.sv
// Request queue between the input parser and the allocator core.
// Holds {id,size} entries. Define FALAFEL_REQ_FIFO_BYPASS_EN to let an entry fall through an empty queue in the same cycle.
package falafel_pkg;
    parameter int DATA_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] id;
        logic [DATA_W-1:0] size;
    } alloc_entry_t;
endpackage

module falafel_req_fifo
    import falafel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_val_i,
    output logic                       in_rdy_o,
    input  logic [DATA_W-1:0]          in_id_i,
    input  logic [DATA_W-1:0]          in_size_i,
    output logic                       out_val_o,
    input  logic                       out_rdy_i,
    output logic [DATA_W-1:0]          out_id_o,
    output logic [DATA_W-1:0]          out_size_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("falafel_req_fifo: DEPTH must be a power of two and >= 2");
    end

    alloc_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    alloc_entry_t  head;
    alloc_entry_t  out_data;

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign full_o  = full;
    assign empty_o = empty;
    assign count_o = CW'(wr_ptr - rd_ptr);

    assign in_rdy_o = !full && !flush_i && !rst_i;
    assign head     = mem[rd_ptr[AW-1:0]];

`ifdef FALAFEL_REQ_FIFO_BYPASS_EN
    logic fall;
    logic pass_through;

    assign fall         = empty && !flush_i && !rst_i;
    assign out_val_o    = fall ? in_val_i : (!empty && !flush_i);
    assign out_data     = fall ? {in_id_i, in_size_i} : head;
    // An entry consumed on the fall-through path never touches storage.
    assign pass_through = fall && in_val_i && out_rdy_i;
    assign wr_en        = in_val_i && in_rdy_o && !pass_through;
    assign rd_en        = out_val_o && out_rdy_i && !fall;
`else
    assign out_val_o = !empty && !flush_i;
    assign out_data  = head;
    assign wr_en     = in_val_i && in_rdy_o;
    assign rd_en     = out_val_o && out_rdy_i;
`endif

    assign out_id_o   = out_val_o ? out_data.id   : '0;
    assign out_size_o = out_val_o ? out_data.size : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {in_id_i, in_size_i};
    end
endmodule
